// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and defaults for the memory-port arbiter.
package mips_mem_pkg;
  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_MEM_LAT = 1;
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester-side handshake bundle for both masters of the memory port.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              ack0;
  logic              gnt0;
  logic [DATA_W-1:0] rdata0;
  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;
  logic              gnt1;
  logic [DATA_W-1:0] rdata1;

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    input  ack0, gnt0, rdata0,
    input  ack1, gnt1, rdata1
  );

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    output ack0, gnt0, rdata0,
    output ack1, gnt1, rdata1
  );
endinterface

// File: rtl/mem_bus_arbiter_rr.sv
// Two-way round-robin pick; the pointer names the port favoured on a tie.
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic       vld_o,
  output logic       idx_o
);
  always_comb begin
    vld_o = |req_i;
    idx_o = 1'b0;
    unique case (1'b1)
      (req_i == 2'b11): idx_o = ptr_i;
      (req_i == 2'b10): idx_o = 1'b1;
      default:          idx_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin owner of the shared memory port and its tristate data bus.
// One single-word transaction at a time: IDLE, MEM_LAT ACCESS cycles, DONE.
module mem_bus_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MEM_LAT = DEF_MEM_LAT
) (
  input  logic              CLK,
  input  logic              RST,
  mem_bus_arbiter_if.slave  bus,
  output logic              MEM_CS,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  inout  wire  [DATA_W-1:0] Mem_Bus
);
  localparam int CNT_W = $clog2(MEM_LAT) + 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

  state_e                   state_q, state_d;
  logic                     ptr_q, ptr_d;
  logic                     own_q, own_d;
  logic                     we_q, we_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [DATA_W-1:0]        wdata_q, wdata_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     cs_q, cs_d;
  logic                     mwe_q, mwe_d;
  logic [ADDR_W-1:0]        maddr_q, maddr_d;
  logic [1:0]               gnt_q, gnt_d;
  logic [1:0]               ack_q, ack_d;
  logic [1:0][DATA_W-1:0]   rd_q, rd_d;

  logic                     pick_vld;
  logic                     pick_idx;
  logic                     sel_we;
  logic [ADDR_W-1:0]        sel_addr;
  logic [DATA_W-1:0]        sel_wdata;

  rr_arbiter2 u_rr (
    .req_i ({bus.req1, bus.req0}),
    .ptr_i (ptr_q),
    .vld_o (pick_vld),
    .idx_o (pick_idx)
  );

  assign sel_we    = pick_idx ? bus.we1    : bus.we0;
  assign sel_addr  = pick_idx ? bus.addr1  : bus.addr0;
  assign sel_wdata = pick_idx ? bus.wdata1 : bus.wdata0;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    maddr_d = maddr_q;
    rd_d    = rd_q;
    cs_d    = 1'b0;
    mwe_d   = 1'b0;
    gnt_d   = 2'b00;
    ack_d   = 2'b00;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          own_d          = pick_idx;
          we_d           = sel_we;
          addr_d         = sel_addr;
          wdata_d        = sel_wdata;
          cnt_d          = CNT_INIT;
          maddr_d        = sel_addr;
          cs_d           = 1'b1;
          mwe_d          = sel_we;
          gnt_d[pick_idx] = 1'b1;
          state_d        = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          // last access cycle: sample read data, then release the bus
          if (!we_q) rd_d[own_q] = Mem_Bus;
          ack_d[own_q] = 1'b1;
          state_d      = DONE;
        end else begin
          cnt_d        = cnt_q - CNT_W'(1);
          cs_d         = 1'b1;
          mwe_d        = we_q;
          gnt_d[own_q] = 1'b1;
        end
      end
      DONE: begin
        ptr_d   = ~own_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      own_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      cs_q    <= 1'b0;
      mwe_q   <= 1'b0;
      maddr_q <= '0;
      gnt_q   <= 2'b00;
      ack_q   <= 2'b00;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      cs_q    <= cs_d;
      mwe_q   <= mwe_d;
      maddr_q <= maddr_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      rd_q    <= rd_d;
    end
  end

  // write data is only on the bus while a write access is in progress
  assign Mem_Bus = mwe_q ? wdata_q : {DATA_W{1'bz}};

  assign MEM_CS     = cs_q;
  assign MEM_WE     = mwe_q;
  assign MEM_ADDR   = maddr_q;
  assign bus.gnt0   = gnt_q[0];
  assign bus.gnt1   = gnt_q[1];
  assign bus.ack0   = ack_q[0];
  assign bus.ack1   = ack_q[1];
  assign bus.rdata0 = rd_q[0];
  assign bus.rdata1 = rd_q[1];
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: transaction-timeline model plus directed
// and random traffic; a second instance runs with MEM_LAT=3.
module tb_mem_bus_arbiter;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic        CLK;
  logic        RST;
  logic        mem_cs_a, mem_we_a, mem_cs_b, mem_we_b;
  logic [31:0] mem_addr_a, mem_addr_b;
  wire  [31:0] bus_a;
  wire  [31:0] bus_b;

  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifa ();
  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifb ();

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT_A)) dut_a (
    .CLK(CLK), .RST(RST), .bus(ifa),
    .MEM_CS(mem_cs_a), .MEM_WE(mem_we_a),
    .MEM_ADDR(mem_addr_a), .Mem_Bus(bus_a)
  );

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT_B)) dut_b (
    .CLK(CLK), .RST(RST), .bus(ifb),
    .MEM_CS(mem_cs_b), .MEM_WE(mem_we_b),
    .MEM_ADDR(mem_addr_b), .Mem_Bus(bus_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic int idx(input logic [31:0] a);
    return int'(a[9:2]);
  endfunction

  // simple memories behind each arbiter
  logic [31:0] mem_a [0:255];
  logic [31:0] mem_b [0:255];
  bit          mem_cleared;

  always @(posedge CLK) begin
    if (RST && !mem_cleared) begin
      for (int i = 0; i < 256; i++) begin
        mem_a[i] <= '0;
        mem_b[i] <= '0;
      end
      mem_b[32]   <= 32'h1234_5678;
      mem_cleared <= 1'b1;
    end else begin
      if (mem_cs_a && mem_we_a) mem_a[idx(mem_addr_a)] <= bus_a;
      if (mem_cs_b && mem_we_b) mem_b[idx(mem_addr_b)] <= bus_b;
    end
  end

  assign bus_a = (mem_cs_a && !mem_we_a) ? mem_a[idx(mem_addr_a)] : 32'hzzzz_zzzz;
  assign bus_b = (mem_cs_b && !mem_we_b) ? mem_b[idx(mem_addr_b)] : 32'hzzzz_zzzz;

  // timeline model for dut_a: a grant at cycle t owns cycles t+1..t+LAT,
  // acks at t+LAT+1, and the port is free again from t+LAT+2
  int          cyc;
  int          t_g;
  int          next_arb;
  bit          mv;
  bit          ref_cleared;
  bit          ptr;
  bit          m_own;
  bit          m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] e_maddr;
  logic [31:0] e_rd [2];
  logic [31:0] ref_mem [0:255];

  initial begin
    cyc = 0;
    t_g = -1000;
    mv  = 1'b0;
  end

  always @(posedge CLK) begin
    if (RST) begin
      if (!ref_cleared) begin
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        ref_cleared = 1'b1;
      end
      t_g      = -1000;
      next_arb = cyc + 1;
      ptr      = 1'b0;
      m_own    = 1'b0;
      m_we     = 1'b0;
      e_maddr  = '0;
      e_rd[0]  = '0;
      e_rd[1]  = '0;
      mv       = 1'b1;
    end else if (mv) begin
      if (t_g + LAT_A == cyc && !m_we) e_rd[m_own] = ref_mem[idx(m_addr)];
      if (cyc >= next_arb && (ifa.req0 || ifa.req1)) begin
        m_own    = (ifa.req0 && ifa.req1) ? ptr : ifa.req1;
        ptr      = !m_own;
        m_we     = m_own ? ifa.we1 : ifa.we0;
        m_addr   = m_own ? ifa.addr1 : ifa.addr0;
        m_wdata  = m_own ? ifa.wdata1 : ifa.wdata0;
        e_maddr  = m_addr;
        t_g      = cyc;
        next_arb = cyc + LAT_A + 2;
        if (m_we) ref_mem[idx(m_addr)] = m_wdata;
      end
    end
    cyc = cyc + 1;
  end

  int n_tests;
  int n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare_a();
    int d;
    bit cs_e;
    bit ack_e;
    if (!mv) return;
    d     = cyc - t_g;
    cs_e  = (d >= 1) && (d <= LAT_A);
    ack_e = (d == LAT_A + 1);
    chk("mem_cs", mem_cs_a, {31'd0, cs_e});
    chk("mem_we", mem_we_a, {31'd0, cs_e && m_we});
    chk("mem_addr", mem_addr_a, e_maddr);
    chk("gnt0", ifa.gnt0, {31'd0, cs_e && !m_own});
    chk("gnt1", ifa.gnt1, {31'd0, cs_e && m_own});
    chk("ack0", ifa.ack0, {31'd0, ack_e && !m_own});
    chk("ack1", ifa.ack1, {31'd0, ack_e && m_own});
    chk("rdata0", ifa.rdata0, e_rd[0]);
    chk("rdata1", ifa.rdata1, e_rd[1]);
    if (cs_e && m_we) begin
      chk("bus_write", bus_a, m_wdata);
    end else if (cs_e) begin
      chk("bus_read", bus_a, ref_mem[idx(m_addr)]);
    end else begin
      n_tests++;
      if (!(bus_a === 32'hzzzz_zzzz || bus_a === 32'h0)) begin
        n_fail++;
        $display("FAIL bus_idle: got %h expected released bus (cycle %0d)", bus_a, cyc);
      end
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    compare_a();
  endtask

  task automatic drive(input int p, input bit r, input bit we,
                       input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      ifa.req0 = r; ifa.we0 = we; ifa.addr0 = a; ifa.wdata0 = d;
    end else begin
      ifa.req1 = r; ifa.we1 = we; ifa.addr1 = a; ifa.wdata1 = d;
    end
  endtask

  task automatic do_txn(input int p, input bit we, input logic [31:0] a,
                        input logic [31:0] d, output int lat);
    logic ack;
    drive(p, 1'b1, we, a, d);
    lat = 0;
    ack = 1'b0;
    while (!ack && lat < 20) begin
      tick();
      lat++;
      ack = (p == 0) ? ifa.ack0 : ifa.ack1;
    end
    drive(p, 1'b0, we, a, d);
  endtask

  bit busy [2];
  int wait_c [2];

  task automatic rand_step(input bit allow_start);
    logic ack, gnt, req;
    for (int p = 0; p < 2; p++) begin
      ack = p ? ifa.ack1 : ifa.ack0;
      gnt = p ? ifa.gnt1 : ifa.gnt0;
      req = p ? ifa.req1 : ifa.req0;
      if (busy[p]) begin
        wait_c[p]++;
        if (ack) begin
          busy[p] = 1'b0;
          if (p == 0) ifa.req0 = 1'b0; else ifa.req1 = 1'b0;
        end else if (wait_c[p] > 40) begin
          n_tests++;
          n_fail++;
          $display("FAIL rand_timeout: port %0d got no ack within 40 cycles", p);
          busy[p] = 1'b0;
          if (p == 0) ifa.req0 = 1'b0; else ifa.req1 = 1'b0;
        end else if (req && gnt && $urandom_range(0, 3) == 0) begin
          if (p == 0) ifa.req0 = 1'b0; else ifa.req1 = 1'b0;
        end
      end else if (allow_start && $urandom_range(0, 2) == 0) begin
        busy[p]   = 1'b1;
        wait_c[p] = 0;
        drive(p, 1'b1, 1'($urandom_range(0, 1)),
              {22'd0, 8'($urandom_range(0, 63)), 2'b00}, $urandom);
      end
    end
  endtask

  int          lat;
  int          cnt;
  int          k_ack0;
  int          ack_port [$];
  int          ack_time [$];
  logic [31:0] d0;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    RST     = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    ifb.req0 = 1'b0; ifb.we0 = 1'b0; ifb.addr0 = '0; ifb.wdata0 = '0;
    ifb.req1 = 1'b0; ifb.we1 = 1'b0; ifb.addr1 = '0; ifb.wdata1 = '0;
    repeat (2) tick();
    RST = 1'b0;
    chk("reset_cs", mem_cs_a, 0);
    chk("reset_addr", mem_addr_a, 0);
    chk("reset_rdata0", ifa.rdata0, 0);
    chk("reset_b_cs", mem_cs_b, 0);
    tick();

    // CPU write then read back
    do_txn(0, 1'b1, 32'h40, 32'hDEAD_BEEF, lat);
    chk("write_latency", lat, 2);
    tick();
    do_txn(0, 1'b0, 32'h40, 32'h0, lat);
    chk("read_latency", lat, 2);
    chk("read_data", ifa.rdata0, 32'hDEAD_BEEF);
    chk("read_rdata1_kept", ifa.rdata1, 0);
    tick();

    // reset in the middle of a write access
    drive(0, 1'b1, 1'b1, 32'h10, 32'h1111_1111);
    tick();
    chk("wr10_cs", mem_cs_a, 1);
    RST = 1'b1;
    drive(0, 1'b0, 1'b1, 32'h10, 32'h1111_1111);
    tick();
    chk("rst_mid_cs", mem_cs_a, 0);
    chk("rst_mid_ack0", ifa.ack0, 0);
    chk("rst_mid_gnt0", ifa.gnt0, 0);
    chk("rst_mid_rdata0", ifa.rdata0, 0);
    RST = 1'b0;
    drive(0, 1'b1, 1'b0, 32'h10, '0);
    drive(1, 1'b1, 1'b0, 32'h40, '0);
    cnt = 0;
    while (!ifa.ack0 && !ifa.ack1 && cnt < 20) begin
      tick();
      cnt++;
    end
    chk("rst_then_port0_first", {31'd0, ifa.ack0}, 1);
    chk("rst_then_latency", cnt, 2);
    drive(0, 1'b0, 1'b0, 32'h10, '0);
    cnt = 0;
    while (!ifa.ack1 && cnt < 20) begin
      tick();
      cnt++;
    end
    chk("rst_then_port1_next", cnt, 3);
    drive(1, 1'b0, 1'b0, 32'h40, '0);
    tick();

    // contention: both hold reads, grants must alternate 0,1,0,1
    RST = 1'b1;
    tick();
    RST = 1'b0;
    drive(0, 1'b1, 1'b0, 32'h40, '0);
    drive(1, 1'b1, 1'b0, 32'h10, '0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (ifa.ack0) begin ack_port.push_back(0); ack_time.push_back(k); end
      if (ifa.ack1) begin ack_port.push_back(1); ack_time.push_back(k); end
    end
    drive(0, 1'b0, 1'b0, 32'h40, '0);
    drive(1, 1'b0, 1'b0, 32'h10, '0);
    chk("contention_acks", ack_port.size(), 4);
    for (int i = 0; i < ack_port.size() && i < 4; i++) begin
      chk("contention_order", ack_port[i], i % 2);
      chk("contention_time", ack_time[i], 2 + 3 * i);
    end
    tick();

    // early drop of req1 with req0 pending behind it
    drive(1, 1'b1, 1'b0, 32'h40, '0);
    tick();
    chk("drop_gnt1", ifa.gnt1, 1);
    drive(1, 1'b0, 1'b0, 32'h80, '0);
    drive(0, 1'b1, 1'b0, 32'h40, '0);
    cnt    = 0;
    k_ack0 = 0;
    for (int k = 2; k <= 8; k++) begin
      tick();
      if (ifa.ack1) cnt++;
      if (ifa.ack0 && k_ack0 == 0) begin
        k_ack0 = k;
        d0     = ifa.rdata0;
        ifa.req0 = 1'b0;
      end
    end
    chk("drop_ack1_once", cnt, 1);
    chk("drop_rdata1", ifa.rdata1, 32'hDEAD_BEEF);
    chk("drop_port0_next", k_ack0, 5);
    chk("drop_port0_data", d0, 32'hDEAD_BEEF);
    ifa.req0 = 1'b0;
    tick();

    // MEM_LAT=3 instance: read of a preloaded word
    ifb.req1 = 1'b1; ifb.addr1 = 32'h80;
    lat = 0;
    cnt = 0;
    while (!ifb.ack1 && lat < 20) begin
      tick();
      lat++;
      if (mem_cs_b) cnt++;
    end
    ifb.req1 = 1'b0;
    chk("lat3_latency", lat, 4);
    chk("lat3_cs_cycles", cnt, 3);
    chk("lat3_rdata1", ifb.rdata1, 32'h1234_5678);
    chk("lat3_rdata0", ifb.rdata0, 0);

    // random mixed traffic on both ports
    busy[0] = 1'b0;
    busy[1] = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      rand_step(1'b1);
    end
    for (int i = 0; i < 60 && (busy[0] || busy[1]); i++) begin
      tick();
      rand_step(1'b0);
    end
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-requester arbiter for the shared memory port: the CS, WE and ADDR lines plus the bidirectional 32-bit Mem_Bus.
- Requester 0 is the MIPS CPU. Requester 1 is a DMA/program-loader master.
- Arbitration is round-robin. Each access is a single-word transaction sequenced by an FSM.
- Sits between the masters and the Memory module in the top-level integration, and is the only driver of the memory-side bus.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 1, number of cycles CS is held per access; must be at least 1. Read data is sampled on the last of these cycles.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- req0  in  1  CPU request, held until ack0.
- we0  in  1  CPU write enable (1=write, 0=read).
- addr0  in  ADDR_W  CPU address.
- wdata0  in  DATA_W  CPU write data.
- ack0  out  1  one-cycle completion pulse to CPU.
- gnt0  out  1  high while the CPU owns the memory.
- rdata0  out  DATA_W  CPU read data.
- req1, we1, addr1, wdata1, ack1, gnt1, rdata1  (same directions/widths as above)  same meanings for requester 1.
- MEM_CS  out  1  memory chip select.
- MEM_WE  out  1  memory write enable.
- MEM_ADDR  out  ADDR_W  memory address.
- Mem_Bus  inout  DATA_W  shared memory data bus.

Behaviour:
- Reset (RST=1 at a rising edge, any state):
  - state=IDLE.
  - MEM_CS=0, MEM_WE=0, MEM_ADDR=0.
  - Mem_Bus high-Z.
  - ack0/1=0, gnt0/1=0, rdata0/1=0.
  - Round-robin pointer = 0, so requester 0 has priority next.
  - Any transaction in flight is abandoned with no ack.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Single request: grant it.
  - Both requesting: grant the port the pointer favours.
  - On grant, latch owner, we, addr, wdata into internal registers; go to ACCESS next cycle. Later changes to that master's inputs are ignored.
- ACCESS (MEM_LAT cycles, tracked by a down-counter):
  - MEM_CS=1; MEM_WE and MEM_ADDR come from the latched values.
  - gnt of the owner is 1.
  - Write: Mem_Bus driven with the latched wdata for every ACCESS cycle.
  - Read: Mem_Bus stays high-Z; the arbiter never drives the bus in a read.
  - On the last ACCESS cycle, a read registers Mem_Bus into the owner's rdata.
  - Then go to DONE.
- DONE (1 cycle):
  - MEM_CS=0, MEM_WE=0, bus high-Z.
  - Owner's ack=1.
  - Pointer is set to favour the other port.
  - Go to IDLE. This gives one turnaround cycle, so no bus contention.
- Latency: request seen in IDLE at cycle t produces ack at cycle t+MEM_LAT+1. Minimum spacing between transactions is MEM_LAT+2 cycles.
- rdataN holds its value until the next read completes on that port. Writes do not change rdataN.
- ack is never asserted on both ports together. gnt0 and gnt1 are mutually exclusive.
- A requester that drops req mid-transaction still gets its transaction completed and ack pulsed. The master must ignore the stale ack.
- A request asserted in the DONE cycle is arbitrated in the following IDLE cycle.
- MEM_ADDR holds its last value when idle; only MEM_CS qualifies it.

Decomposition:
- Shared package mips_mem_pkg holds:
  - the state enum (IDLE/ACCESS/DONE);
  - the default width constants (32);
  - the MEM_LAT default.
- One natural sub-module: rr_arbiter2, a combinational two-way round-robin pick from {req, pointer}. The pointer register stays in the parent.
- The tristate driver and the FSM live in the top of the block.

Test Plan:
- Reset: assert RST mid-ACCESS of a write to 0x10 -> next cycle MEM_CS=0, bus Z, no ack, all outputs 0. A following req0 read wins even if req1 is also high.
- CPU write then read: req0 we0=1 addr0=0x40 wdata0=0xDEADBEEF -> MEM_CS for 1 cycle, ack0 at t+2. Then a read of 0x40 -> rdata0=0xDEADBEEF at ack0, and rdata1 is unchanged.
- Contention: req0 and req1 held together continuously, each doing a read -> grants alternate 0,1,0,1. Each ack arrives every 3 cycles (MEM_LAT=1); gnt0 and gnt1 are never both high.
- Latency parameter: MEM_LAT=3 with a req1 read of 0x80 preloaded with 0x12345678 -> CS high for 3 cycles, ack1 at t+4, rdata1=0x12345678.
- Bus discipline: a monitor on Mem_Bus across a mixed random write/read sequence -> the arbiter drives only during write ACCESS cycles. No X appears on the bus in any read cycle, and there is one Z cycle between consecutive transactions.
- Early drop: req1 deasserted one cycle after grant -> transaction completes with the latched address and ack1 still pulses once. A req0 pending during it is served next.
